// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM frame generator.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF  = 16;
    localparam int UNDR_W_DEF = 8;

    function automatic logic [31:0] cnt_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_frame_gen_counter.sv
// Frame counter for pwm_frame_gen: edge-aligned wrap, or up/down when
// PWM_CENTER_ALIGNED_EN is defined. Flags the load point on ld.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_nxt,
    input  logic             start,
    output logic [CNT_W-1:0] cnt,
    output logic             ld,
    output logic             dir
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_d, dir_q;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!run_nxt) begin
            cnt_d = '0;
            dir_d = 1'b1;
        end else if (start) begin
            // leaving IDLE enters the frame at the top, already heading down
            cnt_d = CNT_MAX;
            dir_d = 1'b0;
        end else if (dir_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = CNT_MAX - ONE;
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d = ONE;
                dir_d = 1'b1;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign ld  = dir_q && (cnt_q == CNT_MAX);
    assign dir = dir_q;
`else
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (!run_nxt || start) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ld  = (cnt_q == CNT_MAX);
    assign dir = 1'b1;
`endif

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_frame_gen.sv
// PWM frame generator: valid/ready duty shadow, frame-boundary reload,
// underrun reporting. Define PWM_CENTER_ALIGNED_EN for up/down frames.
//
// state | meaning
// IDLE  | counter parked at 0, pwm_out low, waiting for en and a duty word
// RUN   | counting frames, duty reloaded from shadow at each load point
module pwm_frame_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int UNDR_W = UNDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  val_in,
    input  logic              val_valid,
    output logic              val_ready,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              underrun,
    output logic [UNDR_W-1:0] undr_cnt,
    output logic              busy
);

    localparam logic [UNDR_W-1:0] UNDR_MAX = UNDR_W'(cnt_max(UNDR_W));
    localparam logic [UNDR_W-1:0] UNDR_ONE = UNDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(cnt_max(CNT_W));

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  duty_d, duty_q;
    logic [CNT_W-1:0]  shadow_d, shadow_q;
    logic              shadow_full_d, shadow_full_q;
    logic              pwm_d, pwm_q;
    logic              frame_start_d, frame_start_q;
    logic              underrun_d, underrun_q;
    logic [UNDR_W-1:0] undr_cnt_d, undr_cnt_q;

    logic              hs, start, load;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_ld, cnt_dir;

    pwm_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_nxt (state_d == RUN),
        .start   (start),
        .cnt     (cnt),
        .ld      (cnt_ld),
        .dir     (cnt_dir)
    );

    always_comb begin
        hs            = val_valid && !shadow_full_q;
        start         = (state_q == IDLE) && en && (shadow_full_q || hs);
        load          = start || ((state_q == RUN) && cnt_ld && en);

        state_d       = state_q;
        duty_d        = duty_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        underrun_d    = 1'b0;
        undr_cnt_d    = undr_cnt_q;

        if (start) begin
            state_d = RUN;
        end else if ((state_q == RUN) && cnt_ld && !en) begin
            state_d = IDLE;
        end

        if (load) begin
            if (shadow_full_q) begin
                duty_d        = shadow_q;
                shadow_full_d = 1'b0;
            end else if (hs) begin
                duty_d = val_in;
            end else begin
                underrun_d = 1'b1;
                if (undr_cnt_q != UNDR_MAX) begin
                    undr_cnt_d = undr_cnt_q + UNDR_ONE;
                end
            end
        end else if (hs) begin
            shadow_d      = val_in;
            shadow_full_d = 1'b1;
        end

        pwm_d = (state_q == RUN) && (cnt < duty_q);
`ifdef PWM_CENTER_ALIGNED_EN
        // first frame cycle is the top: either the turning point or IDLE entry
        frame_start_d = (state_q == RUN) && (cnt_ld || (!cnt_dir && (cnt == CNT_MAX)));
`else
        frame_start_d = (state_q == RUN) && cnt_dir && (cnt == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            duty_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            undr_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            duty_q        <= duty_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            undr_cnt_q    <= undr_cnt_d;
        end
    end

    assign val_ready   = !shadow_full_q;
    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign undr_cnt    = undr_cnt_q;
    assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_pwm_frame_gen.sv
// Directed bench for pwm_frame_gen with a 16-cycle frame and a 2-bit underrun counter.
module tb_pwm_frame_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] val_in;
    logic       val_valid;
    logic       val_ready;
    logic       pwm_out;
    logic       frame_start;
    logic       underrun;
    logic [1:0] undr_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_acc  = 0;
    int ur_acc  = 0;
    int fs_acc  = 0;

    pwm_frame_gen #(.CNT_W(4), .UNDR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .val_in      (val_in),
        .val_valid   (val_valid),
        .val_ready   (val_ready),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .underrun    (underrun),
        .undr_cnt    (undr_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock: drop valid after an accepted handshake, accumulate output activity
    task automatic tick();
        logic hs;
        hs = val_valid && val_ready;
        @(negedge clk);
        if (hs) val_valid = 1'b0;
        hi_acc += int'(pwm_out);
        ur_acc += int'(underrun);
        fs_acc += int'(frame_start);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        hi_acc = 0;
        ur_acc = 0;
        fs_acc = 0;
    endtask

    task automatic send(input logic [3:0] v);
        val_in    = v;
        val_valid = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        val_in    = '0;
        val_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", val_ready, 1);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_undr_cnt", undr_cnt, 0);
        chk("rst_frame_start", frame_start, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start from IDLE with duty 5 (bypass into duty)
        en = 1'b1;
        send(4'd5);
        tick();
        chk("start_busy", busy, 1);
        chk("start_pwm_lat1", pwm_out, 0);
        chk("start_ready", val_ready, 1);
        clr();
        tick();
        chk("start_pwm_lat2", pwm_out, 1);
        chk("start_frame_start", frame_start, 1);
        ticks(3);
        send(4'd3);
        tick();
        chk("ready_low_after_3", val_ready, 0);
        send(4'd12);
        ticks(6);
        chk("ready_low_mid", val_ready, 0);
        ticks(5);
        chk("frameA_hi", hi_acc, 5);
        chk("frameA_fs", fs_acc, 1);
        chk("frameA_ur", ur_acc, 0);

        clr();
        ticks(8);
        chk("frameB_ready_low", val_ready, 0);
        ticks(8);
        chk("frameB_hi", hi_acc, 3);
        chk("frameB_ur", ur_acc, 0);

        // three starved frames
        clr();
        ticks(48);
        chk("starve3_hi", hi_acc, 36);
        chk("starve3_ur", ur_acc, 3);
        chk("starve3_fs", fs_acc, 3);
        chk("starve3_undr_cnt", undr_cnt, 3);

        clr();
        ticks(32);
        chk("starve5_hi", hi_acc, 24);
        chk("starve5_ur", ur_acc, 2);
        chk("starve5_undr_sat", undr_cnt, 3);

        // handshake exactly on the load cycle with an empty shadow
        clr();
        ticks(15);
        chk("frameH_hi_pre", hi_acc, 12);
        send(4'd7);
        tick();
        chk("bypass_no_ur", ur_acc, 0);
        chk("bypass_ready", val_ready, 1);
        clr();
        ticks(5);
        send(4'd0);
        ticks(11);
        chk("bypass_frame_hi", hi_acc, 7);
        chk("bypass_frame_ur", ur_acc, 0);

        clr();
        ticks(5);
        send(4'd15);
        ticks(11);
        chk("duty0_hi", hi_acc, 0);
        chk("duty0_ur", ur_acc, 0);

        clr();
        ticks(16);
        chk("duty15_hi", hi_acc, 15);
        chk("duty15_ur", ur_acc, 1);

        // drop en at cnt 6: frame completes, then idle
        clr();
        ticks(6);
        en = 1'b0;
        ticks(10);
        chk("stop_frame_hi", hi_acc, 15);
        chk("stop_frame_ur", ur_acc, 0);
        chk("stop_busy", busy, 0);
        clr();
        ticks(4);
        chk("idle_hi", hi_acc, 0);
        chk("idle_fs", fs_acc, 0);
        chk("idle_busy", busy, 0);

        // async reset in the middle of a duty-10 pulse with shadow full
        en = 1'b1;
        send(4'd10);
        tick();
        chk("restart_busy", busy, 1);
        tick();
        chk("restart_pwm", pwm_out, 1);
        ticks(3);
        send(4'd9);
        tick();
        chk("pre_rst_pwm", pwm_out, 1);
        chk("pre_rst_ready", val_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_ready", val_ready, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_undr_cnt", undr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        ticks(2);
        chk("post_rst_pwm", pwm_out, 0);
        chk("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
